// File: rtl/cv32e40p_fault_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_fault_monitor_pkg
// Purpose  : Shared types and constants for the fault monitor: FSM state
//            encoding, register byte offsets, CTRL bit positions, and a small
//            helper that counts simultaneous fault events.
// Revision : 1.0 - initial release
// ============================================================================
package cv32e40p_fault_monitor_pkg;

  // Monitor FSM states; the encoding is visible to software in STATUS[5:4]
  typedef enum logic [1:0] {
    FM_IDLE    = 2'b00,
    FM_LOGGING = 2'b01,
    FM_ALARM   = 2'b10
  } fm_state_e;

  // Number of monitored fault sources (ALU faulty 1..3, MULT faulty)
  localparam int c_NUM_SRC = 4;

  // Register byte offsets; only bits [4:2] take part in decoding
  localparam logic [4:0] c_OFF_STATUS = 5'h00;
  localparam logic [4:0] c_OFF_CTRL   = 5'h04;
  localparam logic [4:0] c_OFF_THRESH = 5'h08;
  localparam logic [4:0] c_OFF_CNT0   = 5'h0C;
  localparam logic [4:0] c_OFF_CNT1   = 5'h10;
  localparam logic [4:0] c_OFF_CNT2   = 5'h14;
  localparam logic [4:0] c_OFF_CNT3   = 5'h18;
  localparam logic [4:0] c_OFF_TOTAL  = 5'h1C;

  // CTRL bit positions
  localparam int c_CTRL_EN     = 0;
  localparam int c_CTRL_CLR    = 1;
  localparam int c_CTRL_IRQ_EN = 2;

  // Number of set bits in a 4-bit event vector (0..4)
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_sat_counter
// Purpose  : Up-counter that adds a small increment each cycle and sticks at
//            all-ones instead of wrapping. A synchronous clear takes priority
//            over any increment. The post-update value is also exported so
//            callers can make decisions on it in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_sat_counter #(
  parameter int CNT_WIDTH = 16,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INC_WIDTH-1:0] i_incr,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_value,
  output logic [CNT_WIDTH-1:0] o_next
);

  logic [CNT_WIDTH-1:0] r_value;
  logic [CNT_WIDTH:0]   w_incr_ext;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_next;

  // One extra bit on the sum: since the increment is narrower than the
  // counter, a carry into the top bit means the true sum passed all-ones.
  assign w_incr_ext = {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, i_incr};
  assign w_sum      = {1'b0, r_value} + w_incr_ext;

  // Next value: clear wins, otherwise add and clamp on overflow
  always_comb begin
    w_next = w_sum[CNT_WIDTH-1:0];
    if (i_clr) begin
      w_next = '0;
    end else if (w_sum[CNT_WIDTH]) begin
      w_next = '1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value = r_value;
  assign o_next  = w_next;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_fault_monitor
// Purpose  : Counts rising edges of the core fault levels per source and in
//            total, keeps sticky per-source flags, and raises a level alarm
//            once the total reaches a programmable threshold. Software access
//            is through a simple req/gnt/rvalid register port.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_fault_monitor
  import cv32e40p_fault_monitor_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int THRESH_RST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  fault_i,
  input  logic        reg_req_i,
  output logic        reg_gnt_o,
  output logic        reg_rvalid_o,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        fault_irq_o
);

  // Registered state
  logic [3:0]           r_fault_q;
  logic [3:0]           r_sticky;
  logic                 r_en;
  logic                 r_irq_en;
  logic [CNT_WIDTH-1:0] r_thresh;
  fm_state_e            r_state;
  logic                 r_irq;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;

  // Combinational decode and event logic
  logic [3:0]                          w_evt;
  logic [2:0]                          w_n_evt;
  logic [2:0]                          w_word;
  logic                                w_wr;
  logic                                w_rd;
  logic                                w_wr_status;
  logic                                w_wr_ctrl;
  logic                                w_wr_thresh;
  logic                                w_clr;
  logic [c_NUM_SRC-1:0][CNT_WIDTH-1:0] w_cnt;
  logic [c_NUM_SRC-1:0][CNT_WIDTH-1:0] w_cnt_next;
  logic [CNT_WIDTH-1:0]                w_total;
  logic [CNT_WIDTH-1:0]                w_total_next;
  logic                                w_thr_hit;
  logic [31:0]                         w_rdata;
  logic                                w_unused_bits;

  // A fault event is a 0->1 transition of a level, seen only while enabled
  assign w_evt   = fault_i & ~r_fault_q & {4{r_en}};
  assign w_n_evt = popcount4(w_evt);

  // Register port decode; every request is accepted in the cycle it arrives
  assign reg_gnt_o   = reg_req_i;
  assign w_word      = reg_addr_i[4:2];
  assign w_wr        = reg_req_i & reg_we_i;
  assign w_rd        = reg_req_i & ~reg_we_i;
  assign w_wr_status = w_wr & (w_word == c_OFF_STATUS[4:2]);
  assign w_wr_ctrl   = w_wr & (w_word == c_OFF_CTRL[4:2]);
  assign w_wr_thresh = w_wr & (w_word == c_OFF_THRESH[4:2]);
  assign w_clr       = w_wr_ctrl & reg_wdata_i[c_CTRL_CLR];

  // Per-source event counters
  generate
    for (genvar gi = 0; gi < c_NUM_SRC; gi++) begin : g_cnt
      cv32e40p_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (1)
      ) u_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_incr  (w_evt[gi]),
        .i_clr   (w_clr),
        .o_value (w_cnt[gi]),
        .o_next  (w_cnt_next[gi])
      );
    end
  endgenerate

  // Total counter advances by the number of simultaneous events
  cv32e40p_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .INC_WIDTH (3)
  ) u_total (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_incr  (w_n_evt),
    .i_clr   (w_clr),
    .o_value (w_total),
    .o_next  (w_total_next)
  );

  // Threshold is judged on the total as it will be after this cycle
  assign w_thr_hit = (r_thresh != '0) && (w_total_next >= r_thresh);

  // Per-source next values and the byte-lane address bits are not needed
  assign w_unused_bits = ^{w_cnt_next, reg_addr_i[1:0], reg_wdata_i};

  // Monitor FSM and the alarm output derived from the current state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= FM_IDLE;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= (r_state == FM_ALARM) & r_irq_en;
      if (w_clr) begin
        r_state <= FM_IDLE;
      end else if (r_en) begin
        case (r_state)
          FM_IDLE: begin
            if (w_thr_hit) begin
              r_state <= FM_ALARM;
            end else if (w_total_next != '0) begin
              r_state <= FM_LOGGING;
            end
          end
          FM_LOGGING: begin
            if (w_thr_hit) begin
              r_state <= FM_ALARM;
            end
          end
          FM_ALARM: begin
            r_state <= FM_ALARM;
          end
          default: begin
            r_state <= FM_IDLE;
          end
        endcase
      end
    end
  end

  // Fault level history, sticky flags and software-writable control fields
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fault_q <= '0;
      r_sticky  <= '0;
      r_en      <= 1'b1;
      r_irq_en  <= 1'b1;
      r_thresh  <= CNT_WIDTH'(THRESH_RST);
    end else begin
      r_fault_q <= fault_i;
      // A new event beats a same-cycle write-1-to-clear
      r_sticky  <= (r_sticky & ~(reg_wdata_i[3:0] & {4{w_wr_status}})) | w_evt;
      if (w_wr_ctrl) begin
        r_en     <= reg_wdata_i[c_CTRL_EN];
        r_irq_en <= reg_wdata_i[c_CTRL_IRQ_EN];
      end
      if (w_wr_thresh) begin
        r_thresh <= reg_wdata_i[CNT_WIDTH-1:0];
      end
    end
  end

  // Read mux over the current (pre-update) register contents
  always_comb begin
    w_rdata = '0;
    case (w_word)
      c_OFF_STATUS[4:2]: w_rdata = {26'd0, r_state, r_sticky};
      c_OFF_CTRL[4:2]:   w_rdata = {29'd0, r_irq_en, 1'b0, r_en};
      c_OFF_THRESH[4:2]: w_rdata = 32'(r_thresh);
      c_OFF_CNT0[4:2]:   w_rdata = 32'(w_cnt[0]);
      c_OFF_CNT1[4:2]:   w_rdata = 32'(w_cnt[1]);
      c_OFF_CNT2[4:2]:   w_rdata = 32'(w_cnt[2]);
      c_OFF_CNT3[4:2]:   w_rdata = 32'(w_cnt[3]);
      c_OFF_TOTAL[4:2]:  w_rdata = 32'(w_total);
      default:           w_rdata = '0;
    endcase
  end

  // One-cycle response; read data is zero outside read responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= reg_req_i;
      r_rdata  <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign reg_rvalid_o = r_rvalid;
  assign reg_rdata_o  = r_rdata;
  assign fault_irq_o  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_fault_monitor
// Purpose  : Self-checking bench for the fault monitor. A behavioural model
//            tracks counters, flags, state and the response channel as plain
//            integers; every cycle the DUT outputs are compared with it, and
//            directed scenarios pin the model with hand-computed values.
//            A narrow counter width keeps the saturation scenario short.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_fault_monitor;

  localparam int W    = 8;
  localparam int TR   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fault;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  int          m_cnt[4];
  int          m_total;
  logic [3:0]  m_sticky;
  int          m_state;     // 0 idle, 1 logging, 2 alarm
  bit          m_en;
  bit          m_irq_en;
  int          m_thresh;
  logic [3:0]  m_fq;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          m_irq;

  cv32e40p_fault_monitor #(
    .CNT_WIDTH  (W),
    .THRESH_RST (TR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .fault_i      (fault),
    .reg_req_i    (req),
    .reg_gnt_o    (gnt),
    .reg_rvalid_o (rvalid),
    .reg_we_i     (we),
    .reg_addr_i   (addr),
    .reg_wdata_i  (wdata),
    .reg_rdata_o  (rdata),
    .fault_irq_o  (irq)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > MAXV) ? MAXV : a + b;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int w;
    w = int'(a[4:2]);
    case (w)
      0:       return 32'(m_state * 16 + int'(m_sticky));
      1:       return 32'(int'(m_irq_en) * 4 + int'(m_en));
      2:       return 32'(m_thresh);
      7:       return 32'(m_total);
      default: return 32'(m_cnt[w - 3]);
    endcase
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic model_step();
    int          nev;
    logic [3:0]  evm;
    bit          wr;
    bit          clr;
    int          word;
    logic [31:0] n_rdata;
    bit          n_irq;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_total = 0; m_sticky = 4'h0; m_state = 0; m_en = 1'b1; m_irq_en = 1'b1;
      m_thresh = TR; m_fq = 4'h0; m_rvalid = 1'b0; m_rdata = 32'd0; m_irq = 1'b0;
    end else begin
      nev = 0;
      evm = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (m_en && fault[i] && !m_fq[i]) begin
          evm[i] = 1'b1;
          nev++;
        end
      end
      wr      = req && we;
      word    = int'(addr[4:2]);
      clr     = wr && (word == 1) && wdata[1];
      n_rdata = (req && !we) ? m_read(addr) : 32'd0;
      n_irq   = (m_state == 2) && m_irq_en;
      for (int i = 0; i < 4; i++) m_cnt[i] = clr ? 0 : sat_add(m_cnt[i], int'(evm[i]));
      m_total = clr ? 0 : sat_add(m_total, nev);
      if (wr && word == 0) m_sticky = m_sticky & ~wdata[3:0];
      m_sticky = m_sticky | evm;
      if (clr) begin
        m_state = 0;
      end else if (m_en) begin
        if (m_state != 2 && m_thresh != 0 && m_total >= m_thresh) m_state = 2;
        else if (m_state == 0 && m_total != 0) m_state = 1;
      end
      if (wr && word == 1) begin
        m_en     = wdata[0];
        m_irq_en = wdata[2];
      end
      if (wr && word == 2) m_thresh = int'(wdata[W-1:0]);
      m_fq     = fault;
      m_rvalid = req;
      m_rdata  = n_rdata;
      m_irq    = n_irq;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    idle();
    d = rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1; fault = 4'h0; idle();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(req));
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      check("rdata", rdata, m_rdata);
      check("irq", 32'(irq), 32'(m_irq));
    end
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; fault = 4'h0; idle();
    do_reset();

    // Reset values
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rd(c_addr(0), d); check("rst_status", d, 32'h0);
    rd(c_addr(1), d); check("rst_ctrl", d, 32'h5);
    rd(c_addr(2), d); check("rst_thresh", d, 32'd4);
    rd(c_addr(7), d); check("rst_total", d, 32'd0);

    // Level held for three cycles counts once
    fault = 4'b0001; tick(); tick(); tick();
    fault = 4'b0000; tick(); tick();
    rd(c_addr(3), d); check("pulse_cnt0", d, 32'd1);
    rd(c_addr(7), d); check("pulse_total", d, 32'd1);
    rd(c_addr(0), d); check("pulse_status", d, 32'h11);
    check("pulse_irq", 32'(irq), 32'd0);

    // All four sources at once reach the threshold in one step
    do_reset();
    fault = 4'b1111;
    tick(); check("all_irq_1cyc", 32'(irq), 32'd0);
    tick(); check("all_irq_2cyc", 32'(irq), 32'd1);
    rd(c_addr(7), d); check("all_total", d, 32'd4);
    rd(c_addr(0), d); check("all_status", d, 32'h2F);

    // Clear during alarm with a concurrent event: clear wins, sticky sets
    fault = 4'b0000; tick();
    wr(c_addr(0), 32'hF);
    req = 1'b1; we = 1'b1; addr = c_addr(1); wdata = 32'h7; fault = 4'b0010;
    tick(); idle();
    tick(); check("clr_irq", 32'(irq), 32'd0);
    rd(c_addr(7), d); check("clr_total", d, 32'd0);
    rd(c_addr(4), d); check("clr_cnt1", d, 32'd0);
    rd(c_addr(0), d); check("clr_status", d, 32'h02);
    rd(c_addr(1), d); check("clr_ctrl", d, 32'h5);

    // W1C in the same cycle as a new event leaves the flag set
    fault = 4'b0000; tick();
    req = 1'b1; we = 1'b1; addr = c_addr(0); wdata = 32'h1; fault = 4'b0001;
    tick(); idle(); tick();
    rd(c_addr(0), d); check("w1c_race_status", d, 32'h13);

    // Back-to-back read of TOTAL then write of THRESH
    req = 1'b1; we = 1'b0; addr = c_addr(7);
    tick();
    check("b2b_rvalid0", 32'(rvalid), 32'd1);
    check("b2b_rdata", rdata, 32'd1);
    req = 1'b1; we = 1'b1; addr = c_addr(2); wdata = 32'd0;
    tick(); idle();
    check("b2b_rvalid1", 32'(rvalid), 32'd1);
    tick();
    check("b2b_rvalid_end", 32'(rvalid), 32'd0);
    rd(c_addr(2), d); check("b2b_thresh", d, 32'd0);

    // Disabled monitor ignores events
    wr(c_addr(1), 32'h4);
    fault = 4'b0000; tick();
    fault = 4'b1111; tick();
    fault = 4'b0000; tick();
    rd(c_addr(7), d); check("dis_total", d, 32'd1);
    wr(c_addr(1), 32'h5);

    // Reset in the middle of a write drops response and write
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = c_addr(2); wdata = 32'd9;
    tick();
    rst = 1'b0; idle();
    check("rstmid_rvalid", 32'(rvalid), 32'd0);
    rd(c_addr(2), d); check("rstmid_thresh", d, 32'd4);

    // Saturation of the MULT counter and the total
    do_reset();
    for (int i = 0; i < 300; i++) begin
      fault = 4'b1000; tick();
      fault = 4'b0000; tick();
    end
    rd(c_addr(6), d); check("sat_cnt3", d, 32'(MAXV));
    rd(c_addr(7), d); check("sat_total", d, 32'(MAXV));

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2) == 0) fault = 4'($urandom);
      req  = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 3) == 0);
      addr = 5'($urandom);
      case (addr[4:2])
        3'd1:    wdata = {29'd0, 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0)};
        3'd2:    wdata = 32'($urandom_range(0, 12));
        default: wdata = $urandom;
      endcase
      tick();
    end
    rst = 1'b0; idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  function automatic logic [4:0] c_addr(input int word);
    return 5'(word * 4);
  endfunction

endmodule
`default_nettype wire

// File: doc/cv32e40p_fault_monitor.md
CV32E40P_FAULT_MONITOR -- requirements
Module: cv32e40p_fault_monitor

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, which sets the width of each per-source and total fault counter (range 8..32).
REQ-002 SHALL have parameter THRESH_RST, default 4, which sets the reset value of THRESH.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; one clock domain only.
REQ-004 SHALL have port rst_i, input, 1 bit: reset; synchronous and active-high.
REQ-005 SHALL have port fault_i, input, 4 bits: core fault levels; bits [2:0] are ALU faulty 1..3, bit 3 is MULT faulty; synchronous to clk_i.
REQ-006 SHALL have port reg_req_i, input, 1 bit: register access request.
REQ-007 SHALL have port reg_gnt_o, output, 1 bit: request accepted.
REQ-008 SHALL have port reg_rvalid_o, output, 1 bit: response valid.
REQ-009 SHALL have port reg_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port reg_addr_i, input, 5 bits: byte address; [4:2] selects the word; [1:0] are ignored.
REQ-011 SHALL have port reg_wdata_i, input, 32 bits: write data.
REQ-012 SHALL have port reg_rdata_o, output, 32 bits: read data, valid while reg_rvalid_o=1, otherwise 0.
REQ-013 SHALL have port fault_irq_o, output, 1 bit: fault alarm, level, registered.

Function
REQ-014 SHALL register fault_i once (fault_q); every event is detected on the rising edge fault_i=1 & fault_q=0, i.e. one cycle after the input rises.
REQ-015 SHALL ignore all events while CTRL.EN=0: no counting, no sticky set, no FSM transition.
REQ-016 SHALL, per event, increment the per-source counter CNT[n] by 1, saturating at all-ones.
REQ-017 SHALL increment the total counter TOTAL by the number of simultaneous events (0..4) in one cycle, saturating at all-ones with no wrap.
REQ-018 SHALL, per event, set sticky bit STATUS.STICKY[n]; a write-1-to-clear of STATUS.STICKY clears it.
REQ-019 SHALL, when a sticky set and a W1C hit the same bit in the same cycle, leave the bit set.
REQ-020 SHALL, on a CTRL.CLR write, zero all CNT and TOTAL and move the FSM to IDLE; if an event occurs in the same cycle, the clear wins and the event is not counted (its sticky bit still sets).
REQ-021 SHALL implement FSM states IDLE, LOGGING and ALARM, encoded 2'b00, 2'b01 and 2'b10.
REQ-022 SHALL move IDLE->LOGGING when the post-update TOTAL is nonzero and TOTAL<THRESH (or THRESH=0).
REQ-023 SHALL move IDLE/LOGGING->ALARM when THRESH!=0 and the post-update TOTAL>=THRESH; an IDLE->ALARM jump in one cycle is legal.
REQ-024 SHALL leave ALARM only through CTRL.CLR (to IDLE); raising THRESH while in ALARM does not leave ALARM.
REQ-025 SHALL drive fault_irq_o = (state==ALARM) & CTRL.IRQ_EN, registered, so it asserts 1 cycle after the FSM enters ALARM.
REQ-026 SHALL grant every request combinationally (reg_gnt_o = reg_req_i), with reg_rvalid_o asserted exactly 1 cycle after the grant, for reads and writes alike.
REQ-027 SHALL apply a write in the cycle after the grant; a read returns the value before any same-cycle counter update.
REQ-028 SHALL use this register map:
  - 0x00 STATUS: [3:0] STICKY (W1C), [5:4] FSM state (RO).
  - 0x04 CTRL: [0] EN, [1] CLR (write-only, self-clearing, reads 0), [2] IRQ_EN.
  - 0x08 THRESH: [CNT_WIDTH-1:0] R/W.
  - 0x0C..0x18: CNT[0..3], RO.
  - 0x1C: TOTAL, RO.
REQ-029 SHALL zero-extend register fields to 32 bits, ignore writes to RO fields, and accept back-to-back accesses every cycle.

Reset
REQ-030 SHALL, in a reset cycle, set all of the following to 0: CNT, TOTAL, STICKY, fault_q, reg_rvalid_o, reg_rdata_o and fault_irq_o.
REQ-031 SHALL reset the FSM to IDLE, CTRL to 3'b101 (EN=1, IRQ_EN=1), and THRESH to THRESH_RST.
REQ-032 SHALL, when rst_i asserts mid-access, drop the pending response (no rvalid) and discard any pending write.

Structure
REQ-033 SHALL place the FSM state enum, the register offsets and the CTRL bit indices in a shared package, cv32e40p_fault_monitor_pkg.
REQ-034 SHALL implement the saturating counter as one sub-module, cv32e40p_sat_counter (inputs: incr amount, clr; output: value), instantiated 5 times.

Verification
REQ-035 SHALL cover this case: pulse fault_i=4'b0001 for 3 cycles, then low, with THRESH=4 -> CNT[0]=1, TOTAL=1, STICKY=4'b0001, state=LOGGING, fault_irq_o=0.
REQ-036 SHALL cover this case: fault_i=4'b1111 rises once with THRESH=4 -> TOTAL=4, state=ALARM, and fault_irq_o=1 exactly 2 cycles after fault_i rises.
REQ-037 SHALL cover this case: force CNT[3] to all-ones (toggle bit 3 65536 times at CNT_WIDTH=16), then one more edge -> CNT[3]=0xFFFF, no wrap.
REQ-038 SHALL cover this case: write STATUS=0x1 in the same cycle as a new bit-0 event -> STICKY[0] stays 1.
REQ-039 SHALL cover this case: write CTRL=0x7 during ALARM with a concurrent bit-1 event -> TOTAL=0, CNT[1]=0, STICKY[1]=1, state=IDLE, fault_irq_o=0 the following cycle.
REQ-040 SHALL cover this case: issue a read of 0x1C, then a write of THRESH=0, back-to-back -> rvalid high for 2 consecutive cycles, and read data equals the pre-write TOTAL.
